alu_pwr_ctrl: RTL
=================

ALU_PWR_CTRL -- requirements
Module: alu_pwr_ctrl

Interface
REQ-001 SHALL have parameter ISO_CYCLES, default 2, cycles isolation is held with power on before power-down (legal 1..255).
REQ-002 SHALL have parameter RAMP_CYCLES, default 8, cycles power is held on with domain reset asserted after power-up (legal 1..255).
REQ-003 SHALL have parameter RST_CYCLES, default 4, cycles domain reset is released while isolation is still held (legal 1..255).
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sleep_req  input  1  level request to power the ALU domain down.
REQ-007 wake_req  input  1  level request to power the ALU domain up.
REQ-008 alu_busy  input  1  ALU operation in flight; power-down waits while high.
REQ-009 alu_pwr_en  output  1  ALU domain power switch enable.
REQ-010 iso_en  output  1  isolation/clamp enable at ALU outputs.
REQ-011 alu_rst_n  output  1  ALU domain reset, active-low.
REQ-012 pwr_ready  output  1  high only when ALU is powered, out of reset and de-isolated.
REQ-013 sleep_ack  output  1  high only when the domain is fully off.
REQ-014 state  output  3  current FSM state encoding, for debug.

Function
REQ-015 SHALL implement states ON, DRAIN, ISO, OFF, RAMP, RST_REL; all outputs registered, decoded from next state so they change on the same edge as the state.
REQ-016 Outputs per state (pwr_en/iso_en/alu_rst_n): ON 1/0/1, DRAIN 1/0/1, ISO 1/1/1, OFF 0/1/0, RAMP 1/1/0, RST_REL 1/1/1.
REQ-017 ON -> DRAIN when sleep_req=1 and wake_req=0; sleep_req and wake_req both high in ON SHALL keep ON (wake wins).
REQ-018 DRAIN -> ISO on the first cycle alu_busy=0; DRAIN -> ON if sleep_req drops or wake_req rises before that (abort).
REQ-019 ISO SHALL last exactly ISO_CYCLES cycles, then -> OFF; requests ignored during ISO.
REQ-020 OFF -> RAMP when wake_req=1 (sleep_req value irrelevant).
REQ-021 RAMP SHALL last exactly RAMP_CYCLES cycles, then -> RST_REL; RST_REL exactly RST_CYCLES cycles, then -> ON; requests ignored in both.
REQ-022 Dwell counter 8 bits, loaded with N-1 on state entry, decremented each cycle, exit when zero; no wrap-around is reachable.
REQ-023 iso_en SHALL never be 0 while alu_pwr_en=0 or alu_rst_n=0, in any cycle including reset.
REQ-024 pwr_ready=1 iff state is ON; sleep_ack=1 iff state is OFF.
REQ-025 Requests held through a non-interruptible state SHALL be acted on in the first cycle of the following stable state.

Reset
REQ-026 rst=1 SHALL force state OFF on the next edge: alu_pwr_en=0, iso_en=1, alu_rst_n=0, pwr_ready=0, sleep_ack=1, counter=0.
REQ-027 rst asserted mid-sequence (any state) SHALL take effect the next edge with no intermediate output values.

Structure
REQ-028 State encoding enum and default dwell constants SHALL live in shared package alu_pwr_pkg.
REQ-029 Single module; the dwell counter may be a sub-module named pwr_dwell_cnt.

Verification
REQ-030 Reset then wake_req=1 held: RAMP 8 cycles (pwr_en=1, rst_n=0), RST_REL 4 cycles (iso=1), pwr_ready=1 at cycle 13 after wake seen.
REQ-031 From ON, sleep_req=1 with alu_busy=1 for 5 cycles: DRAIN 5 cycles, ISO exactly 2 cycles, then OFF with sleep_ack=1, pwr_en=0.
REQ-032 From DRAIN, drop sleep_req while alu_busy=1: return to ON next edge, iso_en never asserted.
REQ-033 sleep_req and wake_req both 1 in ON: state stays ON for 20 cycles.
REQ-034 rst pulsed during RAMP cycle 3: next edge OFF, outputs 0/1/0.
REQ-035 Assertion across all tests: iso_en=1 whenever alu_pwr_en=0 or alu_rst_n=0.

Source files
------------

// File: rtl/alu_pwr_pkg.sv
// ALU power-domain controller shared types and defaults.
// Holds the state encoding, dwell defaults and per-state output decode.
package alu_pwr_pkg;

    localparam int CNT_W            = 8;
    localparam int DEF_ISO_CYCLES   = 2;
    localparam int DEF_RAMP_CYCLES  = 8;
    localparam int DEF_RST_CYCLES   = 4;

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ISO     = 3'd2,
        ST_OFF     = 3'd3,
        ST_RAMP    = 3'd4,
        ST_RST_REL = 3'd5
    } pwr_state_e;

    typedef struct packed {
        logic pwr_en;
        logic iso_en;
        logic rst_n;
    } pwr_outs_t;

    function automatic pwr_outs_t state_outs(pwr_state_e s);
        pwr_outs_t o;
        unique case (s)
            ST_ON:      o = '{pwr_en: 1'b1, iso_en: 1'b0, rst_n: 1'b1};
            ST_DRAIN:   o = '{pwr_en: 1'b1, iso_en: 1'b0, rst_n: 1'b1};
            ST_ISO:     o = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b1};
            ST_RAMP:    o = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b0};
            ST_RST_REL: o = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b1};
            default:    o = '{pwr_en: 1'b0, iso_en: 1'b1, rst_n: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pwr_dwell_cnt.sv
// Dwell counter for timed power-sequencing states.
// Ports: clk, rst, load_i/load_val_i (reload), cnt_o, zero_o.
module pwr_dwell_cnt
    import alu_pwr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at zero; a new load always arrives before reuse.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// ALU power-domain sequencer: drain, isolate, power off, ramp, reset release.
// Ports: clk, rst, sleep_req, wake_req, alu_busy -> power/iso/reset/status.
module alu_pwr_ctrl
    import alu_pwr_pkg::*;
#(
    parameter int ISO_CYCLES  = DEF_ISO_CYCLES,
    parameter int RAMP_CYCLES = DEF_RAMP_CYCLES,
    parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       alu_busy,
    output logic       alu_pwr_en,
    output logic       iso_en,
    output logic       alu_rst_n,
    output logic       pwr_ready,
    output logic       sleep_ack,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] ISO_LD  = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] RAMP_LD = CNT_W'(RAMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYCLES - 1);

    pwr_state_e       state_q;
    pwr_state_e       state_d;
    logic             pwr_en_q;
    logic             iso_en_q;
    logic             rst_n_q;
    logic             ready_q;
    logic             ack_q;
    pwr_outs_t        outs_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    pwr_dwell_cnt u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (load_val),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ON: begin
                // Simultaneous wake and sleep keeps the domain up.
                if (sleep_req && !wake_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Abort takes priority over an idle ALU.
                if (!sleep_req || wake_req) state_d = ST_ON;
                else if (!alu_busy)         state_d = ST_ISO;
            end
            ST_ISO: begin
                if (cnt_zero) state_d = ST_OFF;
            end
            ST_OFF: begin
                if (wake_req) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (cnt_zero) state_d = ST_RST_REL;
            end
            ST_RST_REL: begin
                if (cnt_zero) state_d = ST_ON;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Counter reloads on every state change into a timed state.
    always_comb begin
        load     = (state_d != state_q);
        load_val = '0;
        unique case (state_d)
            ST_ISO:     load_val = ISO_LD;
            ST_RAMP:    load_val = RAMP_LD;
            ST_RST_REL: load_val = RST_LD;
            default:    load_val = '0;
        endcase
    end

    assign outs_d = state_outs(state_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            pwr_en_q <= 1'b0;
            iso_en_q <= 1'b1;
            rst_n_q  <= 1'b0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            pwr_en_q <= outs_d.pwr_en;
            iso_en_q <= outs_d.iso_en;
            rst_n_q  <= outs_d.rst_n;
            ready_q  <= (state_d == ST_ON);
            ack_q    <= (state_d == ST_OFF);
        end
    end

    assign alu_pwr_en = pwr_en_q;
    assign iso_en     = iso_en_q;
    assign alu_rst_n  = rst_n_q;
    assign pwr_ready  = ready_q;
    assign sleep_ack  = ack_q;
    assign state      = state_q;

    // Counter value itself is only observed through its zero flag.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule
